// File: rtl/usb_line_conditioner_if.sv
// ---------------------------------------------------------------------------
// usb_line_conditioner_if
//   Bundles the pad-side inputs and the conditioned outputs of the USB line
//   conditioner so the block can be dropped in front of the USB core as one port.
//   Signals:
//     dplus_pad, dminus_pad  raw D+/D- from the pads (asynchronous)
//     d_mode                 1 = core is transmitting (synchronous to clk)
//     dplus_sync/dminus_sync conditioned D+/D- toward the core receiver
//     line_state             filtered state {D-,D+}: 00 SE0, 01 J, 10 K, 11 SE1
//     bus_reset, resume, se1_error  one-clock event pulses
//     reset_active, suspend         bus status levels
//   Modports: master = pad/core side that drives pads and reads results,
//             slave  = the conditioner itself.
// ---------------------------------------------------------------------------
interface usb_line_conditioner_if;
    logic       dplus_pad;
    logic       dminus_pad;
    logic       d_mode;
    logic       dplus_sync;
    logic       dminus_sync;
    logic [1:0] line_state;
    logic       bus_reset;
    logic       reset_active;
    logic       suspend;
    logic       resume;
    logic       se1_error;

    modport master (
        output dplus_pad, dminus_pad, d_mode,
        input  dplus_sync, dminus_sync, line_state,
        input  bus_reset, reset_active, suspend, resume, se1_error
    );

    modport slave (
        input  dplus_pad, dminus_pad, d_mode,
        output dplus_sync, dminus_sync, line_state,
        output bus_reset, reset_active, suspend, resume, se1_error
    );
endinterface

// File: rtl/usb_line_conditioner.sv
// ---------------------------------------------------------------------------
// usb_line_conditioner
//   Receive front end ahead of the USB core: synchronises and deglitches the
//   D+/D- pads, blanks the receive path while the core transmits (and for a
//   short hold afterwards), decodes line state and detects bus reset, suspend
//   and resume.
//   Ports:
//     clk    system clock
//     n_rst  asynchronous active-low reset
//     bus    usb_line_conditioner_if.slave (pads, d_mode, conditioned outputs)
//   Parameters:
//     SYNC_STAGES  synchroniser depth per pad (>=2)
//     FILTER_LEN   equal synced samples needed to accept a new pair (>=1)
//     RESET_CYCLES filtered SE0 clocks that make a bus reset
//     IDLE_CYCLES  filtered J clocks that make suspend
//     BLANK_HOLD   clocks of blanking after d_mode falls
// ---------------------------------------------------------------------------
module usb_line_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 3,
    parameter int RESET_CYCLES = 64,
    parameter int IDLE_CYCLES  = 256,
    parameter int BLANK_HOLD   = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    usb_line_conditioner_if.slave bus
);
    // Pairs are kept as {D-, D+}, which is exactly the line_state encoding.
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    // One shift chain holds both the synchroniser flops and the filter
    // history: stage SYNC_STAGES-1 is the synced sample, the stages beyond it
    // are the previous FILTER_LEN-1 synced samples.
    localparam int DEPTH  = SYNC_STAGES + FILTER_LEN - 1;
    localparam int SE0_W  = $clog2(RESET_CYCLES + 1);
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int BLK_W  = (BLANK_HOLD > 0) ? $clog2(BLANK_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_BUS_RESET = 2'd1,
        ST_SUSPEND   = 2'd2
    } state_t;

    logic [DEPTH-1:0][1:0] r_shift;
    logic [1:0]            r_filt;
    logic                  r_prev_se1;
    logic [SE0_W-1:0]      r_se0_cnt;
    logic [IDLE_W-1:0]     r_idle_cnt;
    logic [BLK_W-1:0]      r_blank_cnt;
    state_t                r_state;

    logic                  w_win_eq;
    logic                  w_blank;
    logic [SE0_W-1:0]      w_se0_next;
    logic [IDLE_W-1:0]     w_idle_next;
    logic                  w_se0_hit;
    logic                  w_idle_hit;
    logic                  w_bus_reset;
    logic                  w_resume;
    state_t                w_state_next;

    // ---------------- synchroniser + filter ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shift <= {DEPTH{LS_J}};
        end else begin
            r_shift <= {r_shift[DEPTH-2:0], {bus.dminus_pad, bus.dplus_pad}};
        end
    end

    always_comb begin
        w_win_eq = 1'b1;
        for (int i = SYNC_STAGES; i < DEPTH; i++) begin
            if (r_shift[i] != r_shift[SYNC_STAGES-1]) w_win_eq = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_filt     <= LS_J;
            r_prev_se1 <= 1'b0;
        end else begin
            if (w_win_eq) r_filt <= r_shift[SYNC_STAGES-1];
            r_prev_se1 <= (r_filt == LS_SE1);
        end
    end

    // ---------------- TX blanking ----------------
    // The counter is reloaded every d_mode clock, so a re-assertion during
    // the hold restarts it; blanking lasts while it is non-zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_blank_cnt <= '0;
        end else if (bus.d_mode) begin
            r_blank_cnt <= BLK_W'(BLANK_HOLD);
        end else if (r_blank_cnt != '0) begin
            r_blank_cnt <= r_blank_cnt - BLK_W'(1);
        end
    end

    assign w_blank = bus.d_mode || (r_blank_cnt != '0);

    // ---------------- line counters ----------------
    // Detection looks at the updated count so the event lands on the Nth
    // qualifying clock.
    always_comb begin
        w_se0_next  = '0;
        w_idle_next = '0;
        if (!w_blank && (r_filt == LS_SE0)) begin
            w_se0_next = (r_se0_cnt == SE0_W'(RESET_CYCLES)) ? r_se0_cnt
                                                              : r_se0_cnt + SE0_W'(1);
        end
        if (!w_blank && (r_filt == LS_J)) begin
            w_idle_next = (r_idle_cnt == IDLE_W'(IDLE_CYCLES)) ? r_idle_cnt
                                                                : r_idle_cnt + IDLE_W'(1);
        end
    end

    assign w_se0_hit  = !w_blank && (w_se0_next == SE0_W'(RESET_CYCLES));
    assign w_idle_hit = !w_blank && (w_idle_next == IDLE_W'(IDLE_CYCLES));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_se0_cnt  <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_se0_cnt  <= w_se0_next;
            r_idle_cnt <= w_idle_next;
        end
    end

    // ---------------- bus state FSM ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= ST_NORMAL;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_bus_reset  = 1'b0;
        w_resume     = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                if (w_se0_hit) begin
                    w_state_next = ST_BUS_RESET;
                    w_bus_reset  = 1'b1;
                end else if (w_idle_hit) begin
                    w_state_next = ST_SUSPEND;
                end
            end
            ST_BUS_RESET: begin
                // SE1 counts as non-SE0 here.
                if (!w_blank && (r_filt != LS_SE0)) w_state_next = ST_NORMAL;
            end
            ST_SUSPEND: begin
                // Core-initiated TX also ends suspend (remote wakeup).
                if (bus.d_mode || (!w_blank && ((r_filt == LS_K) || (r_filt == LS_SE0)))) begin
                    w_resume = 1'b1;
                    if (w_se0_hit) begin
                        w_state_next = ST_BUS_RESET;
                        w_bus_reset  = 1'b1;
                    end else begin
                        w_state_next = ST_NORMAL;
                    end
                end
            end
            default: w_state_next = ST_NORMAL;
        endcase
    end

    // ---------------- outputs ----------------
    // Levels follow the next state so they change on the detecting clock.
    assign bus.dplus_sync   = w_blank ? 1'b1 : r_filt[0];
    assign bus.dminus_sync  = w_blank ? 1'b0 : r_filt[1];
    assign bus.line_state   = w_blank ? LS_J : r_filt;
    assign bus.bus_reset    = w_bus_reset;
    assign bus.reset_active = (w_state_next == ST_BUS_RESET);
    assign bus.suspend      = (w_state_next == ST_SUSPEND);
    assign bus.resume       = w_resume;
    assign bus.se1_error    = !w_blank && (r_filt == LS_SE1) && !r_prev_se1;

endmodule

// File: tb/tb_usb_line_conditioner.sv
// Scoreboard bench: the stimulus pushes expected output events (with the
// cycle they must appear on); the monitor pops one whenever the DUT output
// levels change or a pulse is high, and also runs queued direct checks.
module tb_usb_line_conditioner;
    typedef struct packed {
        int         cyc;
        logic       dp;
        logic       dm;
        logic [1:0] ls;
        logic       br;
        logic       ra;
        logic       su;
        logic       rs;
        logic       se;
    } snap_t;

    logic  clk    = 1'b0;
    logic  n_rst  = 1'b1;
    int    cyc    = 0;
    int    total  = 0;
    int    bad    = 0;
    logic  mon_en = 1'b0;
    logic  fin_req = 1'b0;
    snap_t sb[$];
    snap_t dq[$];

    usb_line_conditioner_if bus();

    usb_line_conditioner #(
        .SYNC_STAGES(2), .FILTER_LEN(3), .RESET_CYCLES(64),
        .IDLE_CYCLES(256), .BLANK_HOLD(2)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dp/dm follow from the line_state encoding {D-,D+}
    function automatic snap_t mk(input int c, input logic [1:0] ls, input logic br,
                                 input logic ra, input logic su, input logic rs, input logic se);
        snap_t s;
        s.cyc = c; s.ls = ls; s.dp = ls[0]; s.dm = ls[1];
        s.br = br; s.ra = ra; s.su = su; s.rs = rs; s.se = se;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("cyc=%0d dp=%b dm=%b ls=%b br=%b ra=%b su=%b rs=%b se=%b",
                         s.cyc, s.dp, s.dm, s.ls, s.br, s.ra, s.su, s.rs, s.se);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pad(input logic dp, input logic dm);
        bus.dplus_pad  = dp;
        bus.dminus_pad = dm;
    endtask

    task automatic push(input int c, input logic [1:0] ls, input logic br, input logic ra,
                        input logic su, input logic rs, input logic se);
        sb.push_back(mk(c, ls, br, ra, su, rs, se));
    endtask

    // ---------------- monitor / checker ----------------
    snap_t cur, prev, e;
    logic  fin_done = 1'b0;

    always @(negedge clk) begin
        cur    = mk(cyc, bus.line_state, bus.bus_reset, bus.reset_active,
                    bus.suspend, bus.resume, bus.se1_error);
        cur.dp = bus.dplus_sync;
        cur.dm = bus.dminus_sync;
        if (dq.size() != 0 && dq[0].cyc == cyc) begin
            e = dq.pop_front();
            total++;
            if (cur !== e) begin
                bad++;
                $display("FAIL direct_check got %s exp %s", fmt(cur), fmt(e));
            end
        end
        if (mon_en && (({cur.dp, cur.dm, cur.ls, cur.ra, cur.su} !== {prev.dp, prev.dm, prev.ls, prev.ra, prev.su})
                       || cur.br || cur.rs || cur.se)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got %s exp none", fmt(cur));
            end else begin
                e = sb.pop_front();
                if (cur !== e) begin
                    bad++;
                    $display("FAIL event got %s exp %s", fmt(cur), fmt(e));
                end
            end
        end
        prev = cur;
        if (fin_req && !fin_done) begin
            fin_done = 1'b1;
            total++;
            if (sb.size() != 0 || dq.size() != 0) begin
                bad++;
                $display("FAIL leftover_expect got events=%0d direct=%0d exp 0/0", sb.size(), dq.size());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        pad(1'b1, 1'b0);
        bus.d_mode = 1'b0;
        #1 n_rst = 1'b0;
        tick(3);
        dq.push_back(mk(cyc, 2'b01, 0, 0, 0, 0, 0));      // reset state
        tick(1);
        n_rst  = 1'b1;
        mon_en = 1'b1;

        // 1: J -> K latency
        tick(2); c = cyc; pad(1'b0, 1'b1); push(c + 5, 2'b10, 0, 0, 0, 0, 0);
        tick(20); c = cyc; pad(1'b1, 1'b0); push(c + 5, 2'b01, 0, 0, 0, 0, 0);

        // 2: 2-clock SE0 glitch is swallowed; 3-clock K passes
        tick(10); pad(1'b0, 1'b0); tick(2); pad(1'b1, 1'b0);
        tick(10); c = cyc; pad(1'b0, 1'b1); push(c + 5, 2'b10, 0, 0, 0, 0, 0);
        tick(3); pad(1'b1, 1'b0); push(c + 8, 2'b01, 0, 0, 0, 0, 0);

        // 3: long SE0 -> bus reset on the 64th filtered SE0 clock
        tick(10); c = cyc; pad(1'b0, 1'b0);
        push(c + 5,  2'b00, 0, 0, 0, 0, 0);
        push(c + 68, 2'b00, 1, 1, 0, 0, 0);
        tick(70); c = cyc; pad(1'b1, 1'b0);
        push(c + 5,   2'b01, 0, 0, 0, 0, 0);             // reset_active drops
        // 4: J continues -> suspend on the 256th filtered J clock
        push(c + 260, 2'b01, 0, 0, 1, 0, 0);
        tick(300); c = cyc; pad(1'b0, 1'b1);
        push(c + 5, 2'b10, 0, 0, 0, 1, 0);                // resume, suspend drops

        // 5: TX blanking with pads at K
        tick(10); c = cyc; bus.d_mode = 1'b1; push(c, 2'b01, 0, 0, 0, 0, 0);
        tick(10); bus.d_mode = 1'b0; push(c + 12, 2'b10, 0, 0, 0, 0, 0);

        // 6: SE1 for 4 clocks -> one se1_error pulse
        tick(20); c = cyc; pad(1'b1, 1'b1); push(c + 5, 2'b11, 0, 0, 0, 0, 1);
        tick(4); pad(1'b0, 1'b1); push(c + 9, 2'b10, 0, 0, 0, 0, 0);

        // async reset in the middle of an SE0 count
        tick(15); c = cyc; pad(1'b0, 1'b0); push(c + 5, 2'b00, 0, 0, 0, 0, 0);
        tick(30); c = cyc;
        push(c, 2'b01, 0, 0, 0, 0, 0);
        dq.push_back(mk(c, 2'b01, 0, 0, 0, 0, 0));
        n_rst = 1'b0;
        pad(1'b1, 1'b0);
        tick(3); n_rst = 1'b1;
        tick(80);
        dq.push_back(mk(cyc, 2'b01, 0, 0, 0, 0, 0));      // no late bus_reset

        tick(2); fin_req = 1'b1;
        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
